// File: rtl/base64_enc_ctrl.sv
// Base64 encoder sequencer: packs 3-byte groups into four sextets, issues one per cycle
// to the encoder and raises '=' pad requests aligned with the encoder's output stream.
module base64_enc_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             start,
    output logic             enc,
    output logic [5:0]       data_in,
    output logic             pad_en,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] char_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [23:0]      r_buf;
    logic [1:0]       r_n;
    logic [1:0]       r_slot;
    logic             r_last;
    logic             r_first;
    logic             r_start;
    logic             r_enc;
    logic [5:0]       r_data_in;
    logic             r_pad_en;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_grp_end;
    logic [23:0]      w_buf_ins;
    logic [1:0]       w_next_slot;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic [5:0] f_sextet(input logic [23:0] b, input logic [1:0] k);
        case (k)
            2'd0:    return b[23:18];
            2'd1:    return b[17:12];
            2'd2:    return b[11:6];
            default: return b[5:0];
        endcase
    endfunction

    assign w_accept    = in_valid && in_ready;
    assign w_grp_end   = (r_idx == 2'd2) || in_last;
    assign w_next_slot = r_slot + 2'd1;
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_buf_ins = r_buf;
        case (r_idx)
            2'd0:    w_buf_ins[23:16] = in_data;
            2'd1:    w_buf_ins[15:8]  = in_data;
            default: w_buf_ins[7:0]   = in_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_buf     <= '0;
            r_n       <= '0;
            r_slot    <= '0;
            r_last    <= 1'b0;
            r_first   <= 1'b0;
            r_start   <= 1'b0;
            r_enc     <= 1'b0;
            r_data_in <= '0;
            r_pad_en  <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_start  <= 1'b0;
            r_enc    <= 1'b0;
            r_pad_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_accept) begin
                        r_buf <= w_buf_ins;
                        if (r_state == S_IDLE) begin
                            r_first <= 1'b1;
                            r_cnt   <= '0;
                        end
                        // Slot 0 is presented on the accept edge so enc follows the final byte directly.
                        if (w_grp_end) begin
                            r_state   <= S_EMIT;
                            r_n       <= r_idx + 2'd1;
                            r_last    <= in_last;
                            r_slot    <= '0;
                            r_enc     <= 1'b1;
                            r_data_in <= f_sextet(w_buf_ins, 2'd0);
                            r_start   <= (r_state == S_IDLE) || r_first;
                        end else begin
                            r_state <= S_COLLECT;
                            r_idx   <= r_idx + 2'd1;
                        end
                    end
                end
                S_EMIT: begin
                    r_cnt <= w_cnt_inc;
                    if (r_slot > r_n) begin
                        r_pad_en <= 1'b1;
                    end
                    if (r_slot == 2'd3) begin
                        r_done  <= r_last;
                        r_first <= 1'b0;
                        r_idx   <= '0;
                        r_buf   <= '0;
                        r_state <= r_last ? S_IDLE : S_COLLECT;
                    end else begin
                        r_slot <= w_next_slot;
                        if (w_next_slot <= r_n) begin
                            r_enc     <= 1'b1;
                            r_data_in <= f_sextet(r_buf, w_next_slot);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state != S_EMIT);
    assign busy     = (r_state != S_IDLE);
    assign start    = r_start;
    assign enc      = r_enc;
    assign data_in  = r_data_in;
    assign pad_en   = r_pad_en;
    assign done     = r_done;
    assign char_cnt = r_cnt;

endmodule

// File: tb/tb_base64_enc_ctrl.sv
// Bench for base64_enc_ctrl: directed messages plus random messages checked against a
// Base64 string model built from the input bytes.
module tb_base64_enc_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             start;
    logic             enc;
    logic [5:0]       data_in;
    logic             pad_en;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] char_cnt;

    base64_enc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .start    (start),
        .enc      (enc),
        .data_in  (data_in),
        .pad_en   (pad_en),
        .done     (done),
        .busy     (busy),
        .char_cnt (char_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    string ALPH = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

    int obs_q[$];
    int start_cnt, done_cnt, done_misalign, overlap_err, last_done_cnt, first_cnt, ready_err;
    bit first_pend;
    logic prev_enc;
    logic [5:0] prev_data;
    byte unsigned msg[$];

    // Merged character stream: encoder char one cycle after enc, or a pad; 64 stands for '='.
    always @(negedge clk) begin
        int got;
        if (reset) begin
            prev_enc   = 1'b0;
            first_pend = 1'b0;
        end else begin
            got = 0;
            if (prev_enc) begin obs_q.push_back(int'(prev_data)); got++; end
            if (pad_en === 1'b1) begin obs_q.push_back(64); got++; end
            if (got == 2) overlap_err++;
            if (got > 0 && first_pend) begin first_cnt = int'(char_cnt); first_pend = 1'b0; end
            if (start === 1'b1) begin start_cnt++; first_pend = 1'b1; end
            if (done === 1'b1) begin
                done_cnt++;
                if (got == 0) done_misalign++;
                last_done_cnt = int'(char_cnt);
            end
            prev_enc  = (enc === 1'b1);
            prev_data = data_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s: got \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    function automatic string to_str(input int q[$]);
        string s = "";
        foreach (q[i]) begin
            if (q[i] == 64) s = {s, "="};
            else s = {s, ALPH.substr(q[i], q[i])};
        end
        return s;
    endfunction

    function automatic string model();
        string s = "";
        for (int i = 0; i < msg.size(); i += 3) begin
            int n;
            int v;
            n = (msg.size() - i > 3) ? 3 : msg.size() - i;
            v = int'(msg[i]) * 65536;
            if (n > 1) v += int'(msg[i+1]) * 256;
            if (n > 2) v += int'(msg[i+2]);
            for (int k = 0; k < 4; k++) begin
                int sx;
                sx = (v >> (18 - 6 * k)) % 64;
                if (k <= n) s = {s, ALPH.substr(sx, sx)};
                else s = {s, "="};
            end
        end
        return s;
    endfunction

    task automatic clear_mon();
        obs_q.delete();
        start_cnt = 0; done_cnt = 0; done_misalign = 0; overlap_err = 0;
        last_done_cnt = -1; first_cnt = -1;
    endtask

    // Returns at the cycle following the last EMIT slot (the done cycle for the final group).
    task automatic send_msg(input bit gaps);
        int gi;
        int waitc;
        gi = 0;
        ready_err = 0;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == msg.size() - 1);
            waitc = 0;
            while (in_ready !== 1'b1 && waitc < 20) begin
                @(posedge clk); #1;
                waitc++;
            end
            chk("ready_wait", waitc < 20, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            gi++;
            if (gi == 3 || i == msg.size() - 1) begin
                gi = 0;
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) begin @(posedge clk); #1; end
                    if (in_ready !== 1'b0 || busy !== 1'b1) ready_err++;
                end
                @(posedge clk); #1;
                if (in_ready !== 1'b1) ready_err++;
            end
        end
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_enc", enc, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_pad_en", pad_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_char_cnt", char_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        msg = '{8'h4D, 8'h61, 8'h6E};
        clear_mon();
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("man_stream", to_str(obs_q), "TWFu");
        chk("man_start", start_cnt, 1);
        chk("man_done", done_cnt, 1);
        chk("man_done_align", done_misalign, 0);
        chk("man_cnt", last_done_cnt, 4);
        chk("man_ready", ready_err, 0);

        msg = '{8'h4D};
        clear_mon();
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("m_stream", to_str(obs_q), "TQ==");
        chk("m_done", done_cnt, 1);
        chk("m_done_align", done_misalign, 0);
        chk("m_cnt", last_done_cnt, 4);

        msg = '{8'h4D, 8'h61};
        clear_mon();
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("ma_stream", to_str(obs_q), "TWE=");
        chk("ma_overlap", overlap_err, 0);

        msg = '{8'h4D, 8'h61, 8'h6E, 8'h79};
        clear_mon();
        send_msg(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk_str("many_stream", to_str(obs_q), "TWFueQ==");
        chk("many_start", start_cnt, 1);
        chk("many_done", done_cnt, 1);
        chk("many_cnt", last_done_cnt, 8);
        chk("many_ready", ready_err, 0);

        msg = '{8'h4D, 8'h61, 8'h6E};
        clear_mon();
        send_msg(1'b0);
        chk("b2b_done_cycle", done, 1);
        chk("b2b_ready_in_done", in_ready, 1);
        msg = '{8'h4D};
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("b2b_stream", to_str(obs_q), "TWFuTQ==");
        chk("b2b_first_cnt", first_cnt, 1);
        chk("b2b_done", done_cnt, 2);
        chk("b2b_start", start_cnt, 2);

        msg = '{8'h4D, 8'h61, 8'h6E};
        clear_mon();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = msg[i];
            in_last = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("mid_slot0_enc", enc, 1);
        chk("mid_slot0_start", start, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_enc", enc, 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_char_cnt", char_cnt, 0);
        @(posedge clk);
        #1;
        clear_mon();
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_no_chars", obs_q.size(), 0);
        chk("mid_no_done", done_cnt, 0);
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("mid_restart_stream", to_str(obs_q), "TWFu");

        for (int m = 0; m < 20; m++) begin
            int len;
            msg.delete();
            len = int'($urandom_range(1, 10));
            for (int b = 0; b < len; b++) msg.push_back(8'($urandom));
            clear_mon();
            send_msg(1'b1);
            repeat (3) @(posedge clk);
            #1;
            chk_str($sformatf("rand%0d_stream", m), to_str(obs_q), model());
            chk($sformatf("rand%0d_done", m), done_cnt, 1);
            chk($sformatf("rand%0d_cnt", m), last_done_cnt, 4 * ((len + 2) / 3));
            chk($sformatf("rand%0d_ready", m), ready_err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/base64_enc_ctrl.md
# base64_enc_ctrl

Sequencer for the Base64 encoder datapath. It accepts a byte stream with a valid/ready handshake and packs each group of 3 bytes into four 6-bit sextets. It issues one sextet per cycle to the encoder's `enc`/`data_in` inputs, and it generates the `=` padding requests for a final short group. It sits between the byte source and the encoder; downstream logic merges encoder `en`/`data_out` with `pad_en` to form the character stream.

## Interface
- `CNT_W`, default 16: width of the per-message character counter.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: block can accept a byte this cycle.
- `in_data` in 8: input byte.
- `in_last` in 1: the qualified byte is the last byte of the message.
- `start` out 1: pulse with the first sextet of a message; drives encoder `start`.
- `enc` out 1: sextet issue strobe; drives encoder `enc`.
- `data_in` out 6: sextet value; drives encoder `data_in`.
- `pad_en` out 1: pad character (`=`) valid. Aligned with the cycle in which the encoder's `en` would be high.
- `done` out 1: one-cycle pulse aligned with the final character (data or pad) of a message.
- `busy` out 1: a message is in progress (state is not IDLE).
- `char_cnt` out CNT_W: characters emitted so far in the current message, including pads.

## Operation
- Reset values:
  - all outputs are 0, except `in_ready` = 1;
  - state = IDLE; byte index = 0; buffer = 0.
- A byte is accepted on `in_valid && in_ready`.
- Bytes b0, b1, b2 are stored in a 24-bit buffer. Missing bytes read as 0.
- States:
  - **IDLE**: `in_ready` = 1. On accept: store b0, index = 1, go to COLLECT. Set an internal first-group flag and clear `char_cnt`. If `in_last` is also set, go to EMIT with n = 1.
  - **COLLECT**: `in_ready` = 1. On each accept, store the byte at the current index and increment the index. When the index reaches 3, or `in_last` is set, go to EMIT with n = bytes held (1–3). Idle cycles (`in_valid` = 0) are allowed indefinitely.
  - **EMIT**: `in_ready` = 0. Four slots k = 0..3, one per cycle.
    - Slot k < n+1: `enc` = 1 and `data_in` = sextet k.
    - Otherwise: `enc` = 0 and a pad is requested.
    - After slot 3: if the group held `in_last`, go to IDLE; else go to COLLECT with index 0 and a cleared buffer.
- Sextets:
  - s0 = b0[7:2]
  - s1 = {b0[1:0], b1[7:4]}
  - s2 = {b1[3:0], b2[7:6]}
  - s3 = b2[5:0]
- Pad count is 3 − n: n = 3 → 0 pads, n = 2 → 1 pad, n = 1 → 2 pads.
- `start` = 1 only in slot 0 of the first group of a message.
- `char_cnt` increments by 1 in every EMIT slot and saturates at 2^CNT_W − 1.
- `data_in` holds its last value when `enc` = 0. Its value is don't-care in that case.
- Empty messages cannot occur, because `in_last` is always qualified by a byte.

## Timing
- `enc`, `data_in` and `start` are registered outputs, asserted in the EMIT slot cycles.
- The encoder presents its character one cycle after `enc`.
- `pad_en` and `done` are registered one cycle after their slot. They therefore coincide with the encoder's `en` stream. At most one of `en`/`pad_en` is high per cycle.
- Latency: the slot-0 `enc` occurs in the cycle after the accept of the group's final byte.
- Full group throughput: 3 accept cycles followed by 4 EMIT cycles, i.e. 7 cycles per 3 bytes with `in_valid` held high.
- There is no back-pressure from downstream; the output stream is never stalled.
- `done` is high in the cycle after slot 3 of the last group. A new message may be accepted in that same cycle, because the state is already IDLE.
- Reset asserted mid-operation:
  - all state clears immediately (asynchronously);
  - the partial group and its pending `pad_en`/`done` are discarded;
  - after release, the block restarts in IDLE.

## Test plan
- Send "Man" (0x4D, 0x61, 0x6E), with `in_last` on 0x6E.
  - Required: `enc` on 4 consecutive cycles with `data_in` = 19, 22, 5, 46.
  - The merged stream is "TWFu", with no `pad_en`.
  - `start` is high on the first slot only; `done` is high with 'u'; `char_cnt` = 4.
- Send "M" with `in_last`.
  - Required: `data_in` = 19, 16, then two pad slots.
  - The stream is "TQ==", with `pad_en` on characters 3 and 4 and `done` on the second pad.
- Send "Ma" with `in_last`.
  - Required: `data_in` = 19, 22, 4, then one pad.
  - The stream is "TWE=".
- Send "Many", with random `in_valid` gaps in COLLECT.
  - Required: `in_ready` = 0 during all 4 EMIT cycles.
  - The stream is "TWFueQ=="; `start` pulses once; `done` pulses once; `char_cnt` = 8.
- Send back-to-back messages "Man" then "M" with no idle cycle.
  - Required: the second message is accepted in the `done` cycle.
  - `char_cnt` restarts at 1; the two messages give "TWFu" and then "TQ==".
- Assert `reset` during slot 1 of "Man".
  - Required: all outputs go to 0 and `in_ready` = 1 immediately, with no `pad_en`/`done` afterwards.
  - A subsequent "Man" then yields "TWFu" correctly.
